// File: rtl/des_engine_arbiter_if.sv
// Requester and engine signal bundle for des_engine_arbiter.
// The slave modport is the arbiter's view. The master modport is the view of
// whatever sits around it: requesters, the DES engine, or a bench.
interface des_engine_arbiter_if #(
    parameter int NUM_REQ = 2
);
    // requester side
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    req_encr;
    logic [64*NUM_REQ-1:0] req_data;
    logic [64*NUM_REQ-1:0] req_key1;
    logic [64*NUM_REQ-1:0] req_key2;
    logic [64*NUM_REQ-1:0] req_key3;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic [63:0]           rsp_data;
    logic                  rsp_error;

    // engine side
    logic                  des_enable;
    logic                  des_encr;
    logic [63:0]           des_data;
    logic [63:0]           des_key1;
    logic [63:0]           des_key2;
    logic [63:0]           des_key3;
    logic [63:0]           des_result;
    logic                  des_done;

    modport slave (
        input  req_valid, req_encr, req_data, req_key1, req_key2, req_key3,
        input  rsp_ready, des_result, des_done,
        output req_ready, rsp_valid, rsp_data, rsp_error,
        output des_enable, des_encr, des_data, des_key1, des_key2, des_key3
    );

    modport master (
        output req_valid, req_encr, req_data, req_key1, req_key2, req_key3,
        output rsp_ready, des_result, des_done,
        input  req_ready, rsp_valid, rsp_data, rsp_error,
        input  des_enable, des_encr, des_data, des_key1, des_key2, des_key3
    );
endinterface

// File: rtl/des_engine_arbiter.sv
// Round-robin sharing of a single triple-DES engine among NUM_REQ requesters.
// Only one job is in flight at a time. The accepted job's operands are latched
// and held on des_*. The engine runs until des_done, or until a watchdog gives
// up and returns an error response. The response is then held until the
// granted requester consumes it.
module des_engine_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 1024
) (
    input logic                 HCLK,
    input logic                 HRESET,
    des_engine_arbiter_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   pick;
    logic               pick_any;
    int                 idx;

    logic [WD_W-1:0]    wdog;
    logic               wdog_expired;

    logic               accept;

    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] rsp_valid;
    logic               des_enable;

    logic               des_encr;
    logic [63:0]        des_data;
    logic [63:0]        des_key1;
    logic [63:0]        des_key2;
    logic [63:0]        des_key3;
    logic [63:0]        rsp_data;
    logic               rsp_error;

    // The watchdog reaches its final value on the TIMEOUT-th engine cycle.
    assign wdog_expired = (wdog == WD_W'(TIMEOUT - 1));
    assign accept       = (state == IDLE) && pick_any;

    // Round-robin search: the first valid requester at or after rr_ptr.
    // Scanning the offsets downward lets the smallest offset win.
    always_comb begin
        pick     = '0;
        pick_any = 1'b0;
        idx      = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (bus.req_valid[idx]) begin
                pick     = IDX_W'(idx);
                pick_any = 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state: des_done is checked ahead of the watchdog so a late completion still counts
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (bus.des_done || wdog_expired) begin
                    state_nx = RESPOND;
                end
            end
            RESPOND: begin
                if (bus.rsp_ready[grant]) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs: the accept pulse is combinational so a requester is acknowledged in its request cycle
    always_comb begin
        req_ready  = '0;
        rsp_valid  = '0;
        des_enable = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    req_ready = NUM_REQ'(1) << pick;
                end
            end
            BUSY: begin
                des_enable = 1'b1;
            end
            RESPOND: begin
                rsp_valid = NUM_REQ'(1) << grant;
            end
            default: ;
        endcase
    end

    // Grant bookkeeping: the pointer moves past the winner, and the watchdog restarts per job
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rr_ptr <= '0;
            grant  <= '0;
            wdog   <= '0;
        end else if (accept) begin
            grant  <= pick;
            rr_ptr <= (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + IDX_W'(1);
            wdog   <= '0;
        end else if (state == BUSY) begin
            wdog   <= wdog + WD_W'(1);
        end
    end

    // Operand capture: held after the job so the engine inputs stay quiet between jobs
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            des_encr <= 1'b0;
            des_data <= '0;
            des_key1 <= '0;
            des_key2 <= '0;
            des_key3 <= '0;
        end else if (accept) begin
            des_encr <= bus.req_encr[pick];
            des_data <= bus.req_data[64*int'(pick) +: 64];
            des_key1 <= bus.req_key1[64*int'(pick) +: 64];
            des_key2 <= bus.req_key2[64*int'(pick) +: 64];
            des_key3 <= bus.req_key3[64*int'(pick) +: 64];
        end
    end

    // Result capture: only while BUSY, so a stray des_done in any other state has no effect
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rsp_data  <= '0;
            rsp_error <= 1'b0;
        end else if (state == BUSY) begin
            if (bus.des_done) begin
                rsp_data  <= bus.des_result;
                rsp_error <= 1'b0;
            end else if (wdog_expired) begin
                rsp_data  <= '0;
                rsp_error <= 1'b1;
            end
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_data   = rsp_data;
    assign bus.rsp_error  = rsp_error;
    assign bus.des_enable = des_enable;
    assign bus.des_encr   = des_encr;
    assign bus.des_data   = des_data;
    assign bus.des_key1   = des_key1;
    assign bus.des_key2   = des_key2;
    assign bus.des_key3   = des_key3;

endmodule

// File: tb/tb_des_engine_arbiter.sv
// Scoreboard bench for des_engine_arbiter: a requester driver with a
// round-robin reference, a behavioural engine, and a response monitor.
module tb_des_engine_arbiter;

    localparam int NR    = 2;
    localparam int TO    = 20;
    localparam int NEVER = 1000;

    logic HCLK   = 1'b0;
    logic HRESET = 1'b1;

    always #5 HCLK = ~HCLK;

    des_engine_arbiter_if #(.NUM_REQ(NR)) bus ();

    des_engine_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
        .HCLK   (HCLK),
        .HRESET (HRESET),
        .bus    (bus)
    );

    typedef struct {
        int          idx;
        logic        encr;
        logic [63:0] data;
        logic [63:0] k1;
        logic [63:0] k2;
        logic [63:0] k3;
        logic [63:0] res;
        int          lat;
    } job_t;

    typedef struct {
        int          idx;
        logic [63:0] data;
        logic        err;
    } rsp_t;

    job_t slot   [NR];
    bit   slot_v [NR];
    job_t eng_q  [$];
    rsp_t exp_q  [$];

    int checks   = 0;
    int failures = 0;

    // reference arbiter state
    bit ref_idle    = 1'b1;
    int ref_rr      = 0;
    bit acc_pend    = 1'b0;
    int acc_idx     = 0;
    int rsp_done    = 0;
    int rsp_seen    = 0;

    // knobs
    bit rdy_rand = 1'b0;
    int hold_req = 0;
    bit spurious = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] onehot(input int i);
        return 64'(1) << i;
    endfunction

    // first pending requester at or after the pointer, -1 if none
    function automatic int ref_pick();
        for (int i = 0; i < NR; i++) begin
            if (slot_v[(ref_rr + i) % NR]) return (ref_rr + i) % NR;
        end
        return -1;
    endfunction

    task automatic load(input int r, input logic encr, input logic [63:0] data,
                        input logic [63:0] res, input int lat);
        slot[r].idx  = r;
        slot[r].encr = encr;
        slot[r].data = data;
        slot[r].k1   = rnd64();
        slot[r].k2   = rnd64();
        slot[r].k3   = rnd64();
        slot[r].res  = res;
        slot[r].lat  = lat;
        slot_v[r]    = 1'b1;
    endtask

    task automatic load_rand(input int r);
        int sel;
        int lat;
        sel = $urandom_range(0, 9);
        if (sel == 0)      lat = TO;
        else if (sel == 1) lat = NEVER;
        else               lat = $urandom_range(1, 8);
        load(r, 1'($urandom), rnd64(), rnd64(), lat);
    endtask

    task automatic drive_reqs();
        for (int r = 0; r < NR; r++) begin
            bus.req_valid[r]           = slot_v[r];
            bus.req_encr[r]            = slot[r].encr;
            bus.req_data[64*r +: 64]   = slot[r].data;
            bus.req_key1[64*r +: 64]   = slot[r].k1;
            bus.req_key2[64*r +: 64]   = slot[r].k2;
            bus.req_key3[64*r +: 64]   = slot[r].k3;
        end
    endtask

    // one clock of the requester driver plus the accept prediction
    task automatic step();
        int   g;
        rsp_t e;
        @(negedge HCLK);
        if (acc_pend) begin
            ref_idle = 1'b0;
            ref_rr   = (acc_idx + 1) % NR;
            acc_pend = 1'b0;
        end
        if (rsp_done != rsp_seen) begin
            ref_idle = 1'b1;
            rsp_seen = rsp_done;
        end
        drive_reqs();
        #1;
        g = ref_idle ? ref_pick() : -1;
        chk("req_ready", 64'(bus.req_ready), (g >= 0) ? onehot(g) : 64'(0));
        if (g >= 0) begin
            e.idx  = g;
            e.err  = (slot[g].lat > TO);
            e.data = e.err ? 64'(0) : slot[g].res;
            exp_q.push_back(e);
            eng_q.push_back(slot[g]);
            acc_pend  = 1'b1;
            acc_idx   = g;
            slot_v[g] = 1'b0;
        end
    endtask

    function automatic bit busy();
        bit any = 1'b0;
        for (int r = 0; r < NR; r++) any |= slot_v[r];
        return any || !ref_idle || acc_pend || (exp_q.size() != 0) || (rsp_done != rsp_seen);
    endfunction

    task automatic drain();
        int n = 0;
        while (busy() && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=busy required=idle at %0t", $time);
        end
    endtask

    task automatic check_zero();
        chk("rst_req_ready",  64'(bus.req_ready),  64'(0));
        chk("rst_rsp_valid",  64'(bus.rsp_valid),  64'(0));
        chk("rst_rsp_data",   bus.rsp_data,        64'(0));
        chk("rst_rsp_error",  64'(bus.rsp_error),  64'(0));
        chk("rst_des_enable", 64'(bus.des_enable), 64'(0));
        chk("rst_des_encr",   64'(bus.des_encr),   64'(0));
        chk("rst_des_data",   bus.des_data,        64'(0));
        chk("rst_des_key1",   bus.des_key1,        64'(0));
        chk("rst_des_key2",   bus.des_key2,        64'(0));
        chk("rst_des_key3",   bus.des_key3,        64'(0));
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        HRESET = 1'b1;
        for (int r = 0; r < NR; r++) slot_v[r] = 1'b0;
        drive_reqs();
        @(negedge HCLK);
        #1;
        ref_idle = 1'b1;
        ref_rr   = 0;
        acc_pend = 1'b0;
        rsp_seen = rsp_done;
        check_zero();
        HRESET = 1'b0;
    endtask

    // behavioural DES engine: completes after the job's latency, checks operands and enable length
    initial begin : engine
        job_t job;
        bit   active = 1'b0;
        int   cnt    = 0;
        bus.des_done   = 1'b0;
        bus.des_result = '0;
        forever begin
            @(negedge HCLK);
            #1;
            if (HRESET) begin
                active       = 1'b0;
                eng_q.delete();
                bus.des_done = 1'b0;
            end else if (bus.des_enable) begin
                if (!active) begin
                    if (eng_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL engine_start actual=enable required=no_job at %0t", $time);
                        job.lat = NEVER;
                        job.idx = 0;
                    end else begin
                        job = eng_q.pop_front();
                        chk("des_data", bus.des_data, job.data);
                        chk("des_key1", bus.des_key1, job.k1);
                        chk("des_key2", bus.des_key2, job.k2);
                        chk("des_key3", bus.des_key3, job.k3);
                        chk("des_encr", 64'(bus.des_encr), 64'(job.encr));
                    end
                    active = 1'b1;
                    cnt    = 0;
                end
                cnt++;
                bus.des_done   = (cnt == job.lat);
                bus.des_result = (cnt == job.lat) ? job.res : rnd64();
            end else begin
                if (active) begin
                    active = 1'b0;
                    chk("enable_len", 64'(cnt), 64'((job.lat < TO) ? job.lat : TO));
                    chk("rsp_after_done", 64'(bus.rsp_valid), onehot(job.idx));
                end
                bus.des_done   = spurious;
                bus.des_result = rnd64();
            end
        end
    end

    // response monitor: stability under back-pressure and scoreboard compare on handshake
    initial begin : monitor
        bit               prev_v = 1'b0;
        logic [NR-1:0]    pv_valid;
        logic [63:0]      pv_data;
        logic             pv_err;
        int               hold = 0;
        logic [NR-1:0]    junk;
        bit               go;
        rsp_t             e;
        bus.rsp_ready = '0;
        forever begin
            @(negedge HCLK);
            #1;
            if (HRESET) begin
                exp_q.delete();
                prev_v        = 1'b0;
                hold          = 0;
                bus.rsp_ready = '0;
            end else begin
                junk = NR'($urandom);
                if (bus.rsp_valid != '0) begin
                    if (prev_v) begin
                        chk("hold_valid", 64'(bus.rsp_valid), 64'(pv_valid));
                        chk("hold_data",  bus.rsp_data,       pv_data);
                        chk("hold_error", 64'(bus.rsp_error), 64'(pv_err));
                    end else if (hold_req > 0) begin
                        hold     = hold_req;
                        hold_req = 0;
                    end
                    if (hold > 0) begin
                        go = 1'b0;
                        hold--;
                    end else begin
                        go = rdy_rand ? 1'($urandom) : 1'b1;
                    end
                    if (go) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL rsp_unexpected actual=%0h required=none at %0t",
                                     bus.rsp_valid, $time);
                        end else begin
                            e = exp_q.pop_front();
                            chk("rsp_valid", 64'(bus.rsp_valid), onehot(e.idx));
                            chk("rsp_data",  bus.rsp_data,       e.data);
                            chk("rsp_error", 64'(bus.rsp_error), 64'(e.err));
                        end
                        rsp_done++;
                        prev_v        = 1'b0;
                        bus.rsp_ready = junk | bus.rsp_valid;
                    end else begin
                        prev_v        = 1'b1;
                        pv_valid      = bus.rsp_valid;
                        pv_data       = bus.rsp_data;
                        pv_err        = bus.rsp_error;
                        bus.rsp_ready = junk & ~bus.rsp_valid;
                    end
                end else begin
                    if (prev_v) begin
                        checks++;
                        failures++;
                        $display("FAIL rsp_dropped actual=0 required=%0h at %0t", pv_valid, $time);
                    end
                    prev_v        = 1'b0;
                    bus.rsp_ready = junk;
                end
            end
        end
    end

    // main sequence
    initial begin : main
        int n;
        int loaded;
        for (int r = 0; r < NR; r++) slot_v[r] = 1'b0;
        bus.req_valid = '0;
        bus.req_encr  = '0;
        bus.req_data  = '0;
        bus.req_key1  = '0;
        bus.req_key2  = '0;
        bus.req_key3  = '0;
        repeat (2) @(negedge HCLK);
        #1;
        check_zero();
        HRESET = 1'b0;

        // single job, 16-cycle engine
        load(0, 1'b1, 64'h0123456789ABCDEF, 64'hDEADBEEFCAFEF00D, 16);
        drain();

        // fairness: both requesters kept asserted
        loaded = 0;
        n      = 0;
        while (loaded < 8 && n < 2000) begin
            for (int r = 0; r < NR; r++) begin
                if (!slot_v[r] && loaded < 8) begin
                    load(r, 1'($urandom), rnd64(), rnd64(), $urandom_range(1, 6));
                    loaded++;
                end
            end
            step();
            n++;
        end
        drain();

        // back-pressure with a second requester waiting
        hold_req = 10;
        load(0, 1'b0, rnd64(), rnd64(), 3);
        load(1, 1'b1, rnd64(), rnd64(), 3);
        drain();

        // watchdog abort, then a normal job
        load(0, 1'b1, rnd64(), rnd64(), NEVER);
        drain();
        load(1, 1'b0, rnd64(), rnd64(), 4);
        drain();

        // done on the watchdog's final cycle
        load(1, 1'b1, rnd64(), rnd64(), TO);
        drain();

        // spurious done while idle
        spurious = 1'b1;
        repeat (3) begin
            step();
            chk("spurious_enable", 64'(bus.des_enable), 64'(0));
            chk("spurious_rsp",    64'(bus.rsp_valid),  64'(0));
        end
        spurious = 1'b0;
        load(0, 1'b0, rnd64(), rnd64(), 2);
        drain();

        // randomized traffic with random consumer back-pressure
        rdy_rand = 1'b1;
        loaded   = 0;
        n        = 0;
        while (loaded < 40 && n < 20000) begin
            for (int r = 0; r < NR; r++) begin
                if (!slot_v[r] && loaded < 40 && $urandom_range(0, 2) == 0) begin
                    load_rand(r);
                    loaded++;
                end
            end
            step();
            n++;
        end
        drain();
        rdy_rand = 1'b0;

        // reset in the middle of a job
        load(0, 1'b1, rnd64(), rnd64(), NEVER);
        n = 0;
        while (slot_v[0] && n < 100) begin
            step();
            n++;
        end
        repeat (3) step();
        do_reset();
        load(0, 1'b1, rnd64(), rnd64(), 5);
        load(1, 1'b0, rnd64(), rnd64(), 5);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/des_engine_arbiter.md
# des_engine_arbiter

Round-robin arbiter and sequencer that shares one triple-DES engine among NUM_REQ requesters (AHB-Lite slave controllers, DMA channels). It accepts one job at a time with a valid/ready handshake and latches that job's data, mode and three keys. It drives the engine's enable until done, then returns the result on a per-requester response handshake. A watchdog aborts jobs the engine never completes.

## Interface
- NUM_REQ, 2, number of requesters, 2..4
- TIMEOUT, 1024, maximum engine cycles per job before abort, ≥ 2
- HCLK  in  1  clock
- HRESET  in  1  synchronous, active-high reset (fixed decision: one clock; reset is synchronous and active-high)
- req_valid  in  NUM_REQ  job request per requester
- req_ready  out  NUM_REQ  one-hot accept pulse
- req_encr  in  NUM_REQ  1 = encrypt, 0 = decrypt, per requester
- req_data  in  64*NUM_REQ  input block, requester i at [64i+63:64i]
- req_key1, req_key2, req_key3  in  64*NUM_REQ each  keys, same packing
- rsp_valid  out  NUM_REQ  one-hot result valid
- rsp_ready  in  NUM_REQ  result consumed
- rsp_data  out  64  result block, shared by all requesters
- rsp_error  out  1  1 = job aborted by watchdog
- des_enable  out  1  engine enable
- des_encr  out  1  engine mode
- des_data, des_key1, des_key2, des_key3  out  64 each  engine operands
- des_result  in  64  engine output block
- des_done  in  1  engine completion

## Operation
- States: IDLE, BUSY, RESPOND.
- IDLE:
  - If any req_valid, grant the first asserted requester at or after rr_ptr, wrapping modulo NUM_REQ.
  - In the same cycle, assert req_ready for the granted requester only, purely from req_valid and rr_ptr.
  - Latch its operands into des_* registers and its index into grant.
  - Set rr_ptr = grant+1 mod NUM_REQ, clear the watchdog, go to BUSY.
- BUSY:
  - des_enable = 1.
  - The watchdog increments each cycle.
  - des_done = 1: capture des_result into rsp_data, set rsp_error = 0, go to RESPOND.
  - Otherwise, when the watchdog reaches TIMEOUT-1: set rsp_data = 0, rsp_error = 1, go to RESPOND.
  - des_done wins if both happen in the same cycle.
- RESPOND:
  - rsp_valid[grant] = 1; rsp_data and rsp_error are held stable.
  - When rsp_ready[grant] = 1: deassert rsp_valid and return to IDLE.
  - rsp_ready on other bits is ignored.
- des_done outside BUSY is ignored.
- des_* operand registers hold the last job's values after the job completes.
- req_valid of non-granted requesters is never acknowledged outside IDLE. Requesters must hold req_valid and operands until req_ready.
- A requester with a pending response is not re-granted before that response completes; this follows from the single-job FSM.
- Reset:
  - State IDLE, rr_ptr = 0, grant = 0, watchdog = 0.
  - All outputs 0: req_ready, rsp_valid, rsp_data, rsp_error, des_enable, des_encr, des_data, des_key1..3.
  - Reset mid-job drops the job with no response, and des_enable falls on the next edge.

## Timing
- Accept cycle T: req_valid & req_ready. des_enable = 1 from T+1.
- des_done sampled at T+k (k ≥ 1): des_enable = 0 and rsp_valid = 1 from T+k+1.
- Zero-wait consumer: rsp_ready at T+k+1 puts the FSM in IDLE at T+k+2, and the next accept can occur in that cycle. Minimum job period is k+2 cycles.
- Abort: rsp_valid with rsp_error at T+TIMEOUT+1 when done never arrives.
- Throughput is one job in flight; there is no pipelining.

## Test plan
- Single job: req 0 with encr = 1, data 0x0123456789ABCDEF, model done at +16 returning 0xDEADBEEFCAFEF00D -> des_enable high exactly 16 cycles; rsp_valid[0] with that data one cycle after done; rsp_error = 0.
- Fairness: req_valid = 2'b11 held continuously, NUM_REQ = 2 -> grants alternate 0,1,0,1; each requester's key1/data reach des_* unchanged.
- Back-pressure: hold rsp_ready low 10 cycles -> rsp_valid and rsp_data stable; no req_ready to the waiting req 1 until the response completes.
- Watchdog: TIMEOUT = 8, des_done never asserted -> rsp_valid with rsp_error = 1 and rsp_data = 0 at T+9; next job is then accepted normally.
- Race and spurious done: des_done on the watchdog's final cycle -> good result, rsp_error = 0. des_done pulsed in IDLE -> no response, no state change.
- Reset mid-BUSY -> all outputs 0 next cycle, rr_ptr = 0; a subsequent req 1 alone is granted immediately.
